divu_unit: RTL

- Multi-cycle 32-bit unsigned divider (restoring, one quotient bit per cycle) in the execute stage.
- Sits directly downstream of the instruction control decoder; is started when the decoder classifies an instruction as `divu` (opcode 000000, func 011011).
- Writes the MIPS HI (remainder) and LO (quotient) registers and raises `busy` so the pipeline stalls until `done`.

---
 rtl/divu_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/divu_unit.sv
// Multi-cycle restoring unsigned divider producing MIPS HI (remainder) / LO (quotient).
// Define DIVU_SIGNED_EN to add the is_signed port and a FIX state serving signed div.
module divu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
`ifdef DIVU_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
`ifdef DIVU_SIGNED_EN
        FIX  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             dbz_r;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
`ifdef DIVU_SIGNED_EN
    logic             neg_q_r;
    logic             neg_r_r;
`endif

    // Operand sign handling and one restoring-division step (WIDTH+1 bit trial subtract).
    always_comb begin
`ifdef DIVU_SIGNED_EN
        neg_a_s = is_signed & dividend[WIDTH-1];
        neg_b_s = is_signed & divisor[WIDTH-1];
`else
        neg_a_s = 1'b0;
        neg_b_s = 1'b0;
`endif
        mag_a_s = neg_a_s ? (~dividend + WIDTH'(1)) : dividend;
        mag_b_s = neg_b_s ? (~divisor + WIDTH'(1)) : divisor;
        shift_s = {rem_r, quo_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, dvs_r};
        if (!trial_s[WIDTH]) begin
            rem_step_s = trial_s[WIDTH-1:0];
            quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = shift_s[WIDTH-1:0];
            quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic; cancel wins over start and aborts anything not yet committed.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (start && !cancel) begin
                    state_next = (divisor == {WIDTH{1'b0}}) ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
`ifdef DIVU_SIGNED_EN
                    state_next = (neg_q_r || neg_r_r) ? FIX : DONE;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = CALC;
                end
            end
`ifdef DIVU_SIGNED_EN
            FIX: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and result registers; HI/LO/dbz change only on the edge entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            dbz_r   <= 1'b0;
`ifdef DIVU_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            state_r <= state_next;
            case (state_r)
                IDLE: begin
                    if (start && !cancel) begin
                        if (divisor == {WIDTH{1'b0}}) begin
                            hi_r  <= dividend;
                            lo_r  <= {WIDTH{1'b1}};
                            dbz_r <= 1'b1;
                        end else begin
                            rem_r <= {WIDTH{1'b0}};
                            quo_r <= mag_a_s;
                            dvs_r <= mag_b_s;
                            cnt_r <= CNT_W'(WIDTH);
`ifdef DIVU_SIGNED_EN
                            neg_q_r <= neg_a_s ^ neg_b_s;
                            neg_r_r <= neg_a_s;
`endif
                        end
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        rem_r <= rem_step_s;
                        quo_r <= quo_step_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (state_next == DONE) begin
                            hi_r  <= rem_step_s;
                            lo_r  <= quo_step_s;
                            dbz_r <= 1'b0;
                        end
                    end
                end
`ifdef DIVU_SIGNED_EN
                FIX: begin
                    if (!cancel) begin
                        hi_r  <= neg_r_r ? (~rem_r + WIDTH'(1)) : rem_r;
                        lo_r  <= neg_q_r ? (~quo_r + WIDTH'(1)) : quo_r;
                        dbz_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy = (state_r != IDLE);
    assign done = (state_r == DONE);
    assign dbz  = dbz_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
